// File: rtl/axi_brom_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_brom_ctrl
// Purpose  : AXI4-Lite slave in front of a single-port 128-bit boot RAM.
//            Serialises AXI reads and writes onto the one RAM port, maps
//            narrow AXI beats onto RAM lines by lane, and absorbs the RAM's
//            one-cycle read latency.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   s_axi_aclk, s_axi_aresetn       clock / async active-low reset
//   s_axi_aw*                       write address channel (1-deep holding reg)
//   s_axi_w*                        write data channel    (1-deep holding reg)
//   s_axi_b*                        write response channel
//   s_axi_ar*                       read address channel (accepted in IDLE)
//   s_axi_r*                        read data channel
//   bram_addra/ena/wea/dina/douta   RAM port, same clock, 1-cycle read latency
// ============================================================================
module axi_brom_ctrl #(
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned BRAM_ADDR_WIDTH = 16,
  parameter int unsigned MEM_DATA_WIDTH  = 128,
  parameter int unsigned WRITE_EN        = 1
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  // write address
  input  logic [BRAM_ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  // write data
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  // write response
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  // read address
  input  logic [BRAM_ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  // read data
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  // RAM port
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_addra,
  output logic                          bram_ena,
  output logic [MEM_DATA_WIDTH/8-1:0]   bram_wea,
  output logic [MEM_DATA_WIDTH-1:0]     bram_dina,
  input  logic [MEM_DATA_WIDTH-1:0]     bram_douta
);

  localparam int unsigned c_AXI_BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned c_LANES     = MEM_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned c_LANE_LSB  = $clog2(c_AXI_BYTES);
  localparam int unsigned c_LANE_W    = $clog2(c_LANES);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_WR_RESP     = (WRITE_EN != 0) ? c_RESP_OKAY : c_RESP_SLVERR;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_EN   = 3'd1,
    S_RD_CAP  = 3'd2,
    S_RD_RESP = 3'd3,
    S_WR_EN   = 3'd4,
    S_WR_RESP = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_live is clear during reset and sets on the first edge afterwards, so
  // every ready output stays low until the block has seen a clock.
  logic                        r_live;

  logic                        r_aw_full;
  logic [BRAM_ADDR_WIDTH-1:0]  r_awaddr;
  logic                        r_w_full;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [c_AXI_BYTES-1:0]      r_wstrb;

  logic [BRAM_ADDR_WIDTH-1:0]  r_araddr;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  // 1 = last grant went to the read side; reset value means WRITE
  logic                        r_last_rd;

  logic                        w_awready;
  logic                        w_wready;
  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_pair;
  logic                        w_idle;
  logic                        w_gnt_rd;
  logic                        w_gnt_wr;

  logic [c_LANE_W-1:0]         w_wr_lane;
  logic [c_LANE_W-1:0]         w_rd_lane;
  logic [MEM_DATA_WIDTH/8-1:0] w_wea;
  logic [MEM_DATA_WIDTH-1:0]   w_dina;
  logic [AXI_DATA_WIDTH-1:0]   w_lane_data [c_LANES];
  logic [AXI_DATA_WIDTH-1:0]   w_rd_slice;

  // --------------------------------------------------------------------------
  // Write capture: AW and W are taken independently into 1-deep holders.
  // --------------------------------------------------------------------------
  assign w_awready = r_live & ~r_aw_full;
  assign w_wready  = r_live & ~r_w_full;
  assign w_aw_hs   = s_axi_awvalid & w_awready;
  assign w_w_hs    = s_axi_wvalid  & w_wready;
  assign w_pair    = r_aw_full & r_w_full;

  // --------------------------------------------------------------------------
  // Arbiter: only decides in IDLE; on conflict it alternates.
  // --------------------------------------------------------------------------
  assign w_idle = r_live & (r_state == S_IDLE);

  always_comb begin
    w_gnt_rd = 1'b0;
    w_gnt_wr = 1'b0;
    if (w_idle) begin
      if (s_axi_arvalid && w_pair) begin
        if (r_last_rd) begin
          w_gnt_wr = 1'b1;
        end else begin
          w_gnt_rd = 1'b1;
        end
      end else if (s_axi_arvalid) begin
        w_gnt_rd = 1'b1;
      end else if (w_pair) begin
        w_gnt_wr = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lane mapping between AXI beats and RAM lines
  // --------------------------------------------------------------------------
  assign w_wr_lane = r_awaddr[c_LANE_LSB +: c_LANE_W];
  assign w_rd_lane = r_araddr[c_LANE_LSB +: c_LANE_W];
  assign w_dina    = {c_LANES{r_wdata}};

  for (genvar g = 0; g < c_LANES; g++) begin : g_lane
    assign w_wea[g*c_AXI_BYTES +: c_AXI_BYTES] =
      (w_wr_lane == c_LANE_W'(g)) ? r_wstrb : '0;
    assign w_lane_data[g] = bram_douta[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

  assign w_rd_slice = w_lane_data[w_rd_lane];

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_live    <= 1'b0;
      r_aw_full <= 1'b0;
      r_awaddr  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_live <= 1'b1;
      // Holders are full (ready low) during WR_EN, so the release here can
      // never collide with a new capture in the same cycle.
      if (r_state == S_WR_EN) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_araddr  <= '0;
      r_rdata   <= '0;
      r_last_rd <= 1'b0;
    end else begin
      if (w_gnt_rd) begin
        r_araddr  <= s_axi_araddr;
        r_last_rd <= 1'b1;
      end else if (w_gnt_wr) begin
        r_last_rd <= 1'b0;
      end
      // RAM data for the RD_EN access is on douta during RD_CAP
      if (r_state == S_RD_CAP) begin
        r_rdata <= w_rd_slice;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and RAM / response outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    bram_ena     = 1'b0;
    bram_wea     = '0;
    bram_addra   = '0;
    bram_dina    = '0;
    s_axi_bvalid = 1'b0;
    s_axi_bresp  = c_RESP_OKAY;
    s_axi_rvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_rd) begin
          w_next = S_RD_EN;
        end else if (w_gnt_wr) begin
          w_next = S_WR_EN;
        end
      end
      S_RD_EN: begin
        bram_ena   = 1'b1;
        bram_addra = r_araddr;
        w_next     = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_next = S_RD_RESP;
      end
      S_RD_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          w_next = S_IDLE;
        end
      end
      S_WR_EN: begin
        // A read-only build still walks through WR_EN so the response timing
        // is identical, but the RAM port is never enabled.
        if (WRITE_EN != 0) begin
          bram_ena = 1'b1;
          bram_wea = w_wea;
        end
        bram_addra = r_awaddr;
        bram_dina  = w_dina;
        w_next     = S_WR_RESP;
      end
      S_WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = c_WR_RESP;
        if (s_axi_bready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_arready = w_gnt_rd;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = c_RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axi_brom_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_brom_ctrl
// Purpose  : Directed self-checking bench for axi_brom_ctrl. Two instances
//            (writable and read-only) share stimulus; sel chooses which one
//            sees the valids and which outputs are observed. Each has its own
//            behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_brom_ctrl;

  localparam logic [127:0] c_LINE0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] c_LINE1 = 128'hA0A1A2A3A4A5A6A7B0B1B2B3B4B5B6B7;

  logic        clk;
  logic        rstn;
  logic        preload;
  logic        sel;
  logic [15:0] awaddr, araddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;

  // writable instance
  logic        rw_awready, rw_wready, rw_bvalid, rw_arready, rw_rvalid, rw_ena;
  logic [1:0]  rw_bresp, rw_rresp;
  logic [63:0] rw_rdata;
  logic [15:0] rw_addra, rw_wea;
  logic [127:0] rw_dina, rw_douta;
  // read-only instance
  logic        ro_awready, ro_wready, ro_bvalid, ro_arready, ro_rvalid, ro_ena;
  logic [1:0]  ro_bresp, ro_rresp;
  logic [63:0] ro_rdata;
  logic [15:0] ro_addra, ro_wea;
  logic [127:0] ro_dina, ro_douta;

  logic [127:0] mem_rw [16];
  logic [127:0] mem_ro [16];
  logic         ro_bad;

  int n_vec = 0;
  int n_err = 0;

  // observed (selected) outputs
  wire        m_awready = sel ? ro_awready : rw_awready;
  wire        m_wready  = sel ? ro_wready  : rw_wready;
  wire        m_arready = sel ? ro_arready : rw_arready;
  wire        m_bvalid  = sel ? ro_bvalid  : rw_bvalid;
  wire [1:0]  m_bresp   = sel ? ro_bresp   : rw_bresp;
  wire        m_rvalid  = sel ? ro_rvalid  : rw_rvalid;
  wire [1:0]  m_rresp   = sel ? ro_rresp   : rw_rresp;
  wire [63:0] m_rdata   = sel ? ro_rdata   : rw_rdata;
  wire        m_ena     = sel ? ro_ena     : rw_ena;
  wire [15:0] m_wea     = sel ? ro_wea     : rw_wea;
  wire [15:0] m_addra   = sel ? ro_addra   : rw_addra;
  wire [127:0] m_dina   = sel ? ro_dina    : rw_dina;

  axi_brom_ctrl #(.WRITE_EN(1)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid & ~sel), .s_axi_awready(rw_awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid & ~sel), .s_axi_wready(rw_wready),
    .s_axi_bresp(rw_bresp), .s_axi_bvalid(rw_bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid & ~sel), .s_axi_arready(rw_arready),
    .s_axi_rdata(rw_rdata), .s_axi_rresp(rw_rresp), .s_axi_rvalid(rw_rvalid), .s_axi_rready(rready),
    .bram_addra(rw_addra), .bram_ena(rw_ena), .bram_wea(rw_wea), .bram_dina(rw_dina),
    .bram_douta(rw_douta)
  );

  axi_brom_ctrl #(.WRITE_EN(0)) dut_ro (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid & sel), .s_axi_awready(ro_awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid & sel), .s_axi_wready(ro_wready),
    .s_axi_bresp(ro_bresp), .s_axi_bvalid(ro_bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid & sel), .s_axi_arready(ro_arready),
    .s_axi_rdata(ro_rdata), .s_axi_rresp(ro_rresp), .s_axi_rvalid(ro_rvalid), .s_axi_rready(rready),
    .bram_addra(ro_addra), .bram_ena(ro_ena), .bram_wea(ro_wea), .bram_dina(ro_dina),
    .bram_douta(ro_douta)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAMs: read-first, registered output.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        mem_rw[i] <= '0;
        mem_ro[i] <= '0;
      end
      mem_rw[0] <= c_LINE0;
      mem_rw[1] <= c_LINE1;
      mem_ro[0] <= c_LINE0;
      ro_bad    <= 1'b0;
    end else begin
      if (rw_ena) begin
        rw_douta <= mem_rw[rw_addra[7:4]];
        for (int b = 0; b < 16; b++)
          if (rw_wea[b]) mem_rw[rw_addra[7:4]][b*8 +: 8] <= rw_dina[b*8 +: 8];
      end
      if (ro_ena) begin
        ro_douta <= mem_ro[ro_addra[7:4]];
        for (int b = 0; b < 16; b++)
          if (ro_wea[b]) mem_ro[ro_addra[7:4]][b*8 +: 8] <= ro_dina[b*8 +: 8];
      end
      if (ro_wea != '0) ro_bad <= 1'b1;
    end
  end

  task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_hs(input logic [15:0] a);
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    #1;
    while (!m_arready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk_val("ar_wait_timeout", 0, 1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [63:0] exp);
    ar_hs(a);
    chk_val({tag, "_ena"}, m_ena, 1);
    chk_val({tag, "_addr"}, m_addra, a);
    tick();
    chk_val({tag, "_rv_early"}, m_rvalid, 0);
    tick();
    chk_val({tag, "_rvalid"}, m_rvalid, 1);
    chk_val({tag, "_rdata"}, m_rdata, exp);
    chk_val({tag, "_rresp"}, m_rresp, 0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk_val({tag, "_rv_clr"}, m_rvalid, 0);
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [15:0] exp_wea,
                        input logic exp_ena, input logic [1:0] exp_resp);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!(m_awready && m_wready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk_val({tag, "_aw_w_timeout"}, 0, 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk_val({tag, "_wea"}, m_wea, exp_wea);
    chk_val({tag, "_ena"}, m_ena, exp_ena);
    if (exp_ena) chk_val({tag, "_dina"}, m_dina, {d, d});
    tick();
    chk_val({tag, "_bvalid"}, m_bvalid, 1);
    chk_val({tag, "_bresp"}, m_bresp, exp_resp);
    chk_val({tag, "_wea_off"}, m_wea, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk_val({tag, "_bv_clr"}, m_bvalid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; preload = 1'b1; sel = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    arvalid = 1'b1;      // must not leak through to arready during reset
    tick();
    preload = 1'b0;
    tick();

    // ---------------- reset state ----------------
    chk_val("rst_awready", m_awready, 0);
    chk_val("rst_wready",  m_wready,  0);
    chk_val("rst_arready", m_arready, 0);
    chk_val("rst_bvalid",  m_bvalid,  0);
    chk_val("rst_bresp",   m_bresp,   0);
    chk_val("rst_rvalid",  m_rvalid,  0);
    chk_val("rst_rdata",   m_rdata,   0);
    chk_val("rst_ena",     m_ena,     0);
    chk_val("rst_wea",     m_wea,     0);
    chk_val("rst_addra",   m_addra,   0);
    chk_val("rst_dina",    m_dina,    0);
    arvalid = 1'b0;
    rstn = 1'b1;
    #1;
    chk_val("rel_awready_pre", m_awready, 0);
    tick();
    chk_val("rel_awready", m_awready, 1);
    chk_val("rel_wready",  m_wready,  1);

    // ---------------- reads, both lanes ----------------
    rd_chk("rd_l1", 16'h0008, 64'h0011223344556677);
    rd_chk("rd_l0", 16'h0000, 64'h8899AABBCCDDEEFF);

    // ---------------- strobed write, W before AW ----------------
    wdata = 64'h1122334455667788; wstrb = 8'h0F; wvalid = 1'b1;
    #1;
    chk_val("sw_wready", m_wready, 1);
    tick();
    wvalid = 1'b0;
    tick();
    tick();
    awaddr = 16'h0018; awvalid = 1'b1;
    #1;
    chk_val("sw_awready", m_awready, 1);
    chk_val("sw_wready_held", m_wready, 0);
    tick();
    awvalid = 1'b0;
    tick();
    chk_val("sw_wea",   m_wea,   16'h0F00);
    chk_val("sw_ena",   m_ena,   1);
    chk_val("sw_addra", m_addra, 16'h0018);
    chk_val("sw_dina",  m_dina,  {2{64'h1122334455667788}});
    tick();
    chk_val("sw_wea_once", m_wea, 0);
    chk_val("sw_bvalid", m_bvalid, 1);
    chk_val("sw_bresp",  m_bresp,  0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    rd_chk("sw_rb_hi", 16'h0018, 64'hA0A1A2A355667788);
    rd_chk("sw_rb_lo", 16'h0010, 64'hB0B1B2B3B4B5B6B7);

    // ---------------- R back-pressure ----------------
    ar_hs(16'h0008);
    tick();
    tick();
    araddr = 16'h0000; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_val("rbp_rvalid",  m_rvalid,  1);
      chk_val("rbp_rdata",   m_rdata,   64'h0011223344556677);
      chk_val("rbp_arready", m_arready, 0);
      chk_val("rbp_ena",     m_ena,     0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    #1;
    chk_val("rbp_next_arready", m_arready, 1);
    tick();
    arvalid = 1'b0;
    chk_val("rbp_next_ena", m_ena, 1);
    tick();
    tick();
    chk_val("rbp_next_rdata", m_rdata, 64'h8899AABBCCDDEEFF);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // ---------------- B back-pressure ----------------
    awaddr = 16'h0030; wdata = 64'h0F0E0D0C0B0A0908; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk_val("bbp_wea", m_wea, 16'h00FF);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_val("bbp_bvalid",  m_bvalid,  1);
      chk_val("bbp_bresp",   m_bresp,   0);
      chk_val("bbp_ena",     m_ena,     0);
      chk_val("bbp_wea_off", m_wea,     0);
      chk_val("bbp_awready", m_awready, 1);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk_val("bbp_bv_clr", m_bvalid, 0);
    rd_chk("bbp_rb", 16'h0030, 64'h0F0E0D0C0B0A0908);

    // ---------------- read-only instance ----------------
    sel = 1'b1;
    #1;
    wr_chk("ro_wr", 16'h0000, 64'hDEADBEEFDEADBEEF, 8'hFF, 16'h0000, 1'b0, 2'b10);
    rd_chk("ro_rd", 16'h0000, 64'h8899AABBCCDDEEFF);
    chk_val("ro_wea_seen", ro_bad, 0);
    sel = 1'b0;
    #1;

    // ---------------- reset during WR_EN ----------------
    awaddr = 16'h0030; wdata = 64'hDEADDEADDEADDEAD; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk_val("mr_ena_pre", m_ena, 1);
    rstn = 1'b0;
    #1;
    chk_val("mr_ena",     m_ena,     0);
    chk_val("mr_wea",     m_wea,     0);
    chk_val("mr_dina",    m_dina,    0);
    chk_val("mr_awready", m_awready, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk_val("mr_no_bvalid", m_bvalid, 0);
    tick();
    chk_val("mr_no_bvalid2", m_bvalid, 0);
    chk_val("mr_awready_up", m_awready, 1);

    // ---------------- conflict 1: last grant is WRITE, read wins ----------------
    awaddr = 16'h0020; wdata = 64'h0123456789ABCDEF; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 16'h0008; arvalid = 1'b1;
    #1;
    chk_val("cf1_arready", m_arready, 1);
    tick();
    arvalid = 1'b0;
    chk_val("cf1_rd_ena", m_ena, 1);
    chk_val("cf1_rd_wea", m_wea, 0);
    tick();
    tick();
    chk_val("cf1_rdata", m_rdata, 64'h0011223344556677);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    tick();
    chk_val("cf1_wea",   m_wea,   16'h00FF);
    chk_val("cf1_waddr", m_addra, 16'h0020);
    tick();
    chk_val("cf1_bvalid", m_bvalid, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // plain read (last grant becomes READ); also confirms the dropped write
    rd_chk("mr_rb", 16'h0030, 64'h0F0E0D0C0B0A0908);

    // ---------------- conflict 2: last grant is READ, write wins ----------------
    awaddr = 16'h0028; wdata = 64'hCAFEF00D12345678; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 16'h0020; arvalid = 1'b1;
    #1;
    chk_val("cf2_arready", m_arready, 0);
    tick();
    chk_val("cf2_wea", m_wea, 16'hFF00);
    tick();
    chk_val("cf2_bvalid", m_bvalid, 1);
    chk_val("cf2_arready_busy", m_arready, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #1;
    chk_val("cf2_arready_after", m_arready, 1);
    tick();
    arvalid = 1'b0;
    tick();
    tick();
    chk_val("cf2_rdata", m_rdata, 64'h0123456789ABCDEF);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    rd_chk("cf2_rb", 16'h0028, 64'hCAFEF00D12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
